// File: rtl/pipe_reg_nwrite_port.sv
// ---------------------------------------------------------------------------
// pipe_reg_nwrite_port
//
// Multi-writer elastic pipe stage. NPORTS producers compete through a
// fixed-priority arbiter (lowest index wins) for a DEPTH-entry FIFO. The
// FIFO drains towards a lower stage that signals readiness with low_empty.
// Lost writes are counted in a saturating drop counter:
//   - collision losers
//   - the winner when the stage is full and nothing is draining, OVERWRITE=0
//
// Ports
//   clock      : rising-edge clock
//   rst        : asynchronous active-high reset
//   wr_en      : per-port write request            [NPORTS]
//   indata     : packed write data, port i at [i*DSIZE +: DSIZE]
//   low_empty  : lower stage ready; head consumed when valid & low_empty
//   clr_drop   : synchronous clear of drop_cnt (wins over same-cycle losses)
//   grant      : one-hot winning port (combinational), zero when idle
//   valid      : head entry present
//   curr_empty : !valid
//   sum_empty  : curr_empty | low_empty
//   full       : level == DEPTH
//   level      : stored entry count
//   outdata    : head entry data, zero when !valid
//   drop_cnt   : saturating count of lost writes
// ---------------------------------------------------------------------------
module pipe_reg_nwrite_port #(
    parameter int DSIZE     = 8,
    parameter int NPORTS    = 2,
    parameter int DEPTH     = 2,
    parameter int OVERWRITE = 0,
    parameter int DROP_W    = 8
) (
    input  logic                         clock,
    input  logic                         rst,
    input  logic [NPORTS-1:0]            wr_en,
    input  logic [NPORTS*DSIZE-1:0]      indata,
    input  logic                         low_empty,
    input  logic                         clr_drop,
    output logic [NPORTS-1:0]            grant,
    output logic                         valid,
    output logic                         curr_empty,
    output logic                         sum_empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [DSIZE-1:0]             outdata,
    output logic [DROP_W-1:0]            drop_cnt
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(NPORTS + 1);
    // Sum width large enough that drop_cnt + losses can never wrap.
    localparam int SW = DROP_W + CW;
    localparam logic [PW-1:0]     LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [LW-1:0]     DEPTH_LVL = LW'(DEPTH);
    localparam logic [DROP_W-1:0] DROP_MAX  = '1;
    localparam logic              OVW_EN    = (OVERWRITE != 0);

    // Storage (contents are never reset; hidden behind valid)
    logic [DSIZE-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [DROP_W-1:0] r_drop_cnt;

    logic [NPORTS:0]  w_req_below;
    logic             w_any;
    logic [DSIZE-1:0] w_win_data;
    logic [CW-1:0]    w_req_cnt;
    logic [CW-1:0]    w_losses;
    logic             w_valid;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_ovw;
    logic             w_full_loss;
    logic [PW-1:0]    w_newest;
    logic [PW-1:0]    w_wr_ptr_next;
    logic [PW-1:0]    w_rd_ptr_next;
    logic [LW-1:0]    w_level_next;
    logic [SW-1:0]    w_drop_sum;
    logic [DROP_W-1:0] w_drop_next;

    // Fixed-priority arbiter: a port wins when no lower-indexed port requests.
    assign w_req_below[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_arb
            assign w_req_below[gi+1] = w_req_below[gi] | wr_en[gi];
            assign grant[gi]         = wr_en[gi] & ~w_req_below[gi];
        end
    endgenerate
    assign w_any = w_req_below[NPORTS];

    // One-hot OR mux of the winner's data, plus request population count.
    always_comb begin
        w_win_data = '0;
        w_req_cnt  = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (grant[i]) begin
                w_win_data = w_win_data | indata[i*DSIZE +: DSIZE];
            end
            w_req_cnt = w_req_cnt + CW'(wr_en[i]);
        end
    end

    assign w_valid = (r_level != '0);
    assign w_full  = (r_level == DEPTH_LVL);
    assign w_pop   = w_valid & low_empty;
    assign w_push  = w_any & (~w_full | w_pop);

    // Full with nothing draining: either replace the newest entry or lose it.
    assign w_ovw       = OVW_EN  & w_any & w_full & ~w_pop;
    assign w_full_loss = ~OVW_EN & w_any & w_full & ~w_pop;

    // Every requester except the winner is a collision loss.
    assign w_losses = (w_any ? (w_req_cnt - CW'(1)) : '0) + CW'(w_full_loss);

    assign w_newest      = (r_wr_ptr == '0) ? LAST_PTR : (r_wr_ptr - PW'(1));
    assign w_wr_ptr_next = (r_wr_ptr == LAST_PTR) ? '0 : (r_wr_ptr + PW'(1));
    assign w_rd_ptr_next = (r_rd_ptr == LAST_PTR) ? '0 : (r_rd_ptr + PW'(1));

    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + LW'(1);
        end else if (w_pop && !w_push) begin
            w_level_next = r_level - LW'(1);
        end
    end

    assign w_drop_sum  = SW'(r_drop_cnt) + SW'(w_losses);
    assign w_drop_next = (w_drop_sum > SW'(DROP_MAX)) ? DROP_MAX : w_drop_sum[DROP_W-1:0];

    // Storage write port; rst gating keeps a write in the reset cycle out.
    always_ff @(posedge clock) begin
        if (!rst) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_win_data;
            end else if (w_ovw) begin
                r_mem[w_newest] <= w_win_data;
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= w_wr_ptr_next;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_next;
            end
            r_level <= w_level_next;
            if (clr_drop) begin
                r_drop_cnt <= '0;
            end else begin
                r_drop_cnt <= w_drop_next;
            end
        end
    end

    // Status outputs come from registers only (sum_empty also sees low_empty).
    assign valid      = w_valid;
    assign curr_empty = ~w_valid;
    assign sum_empty  = ~w_valid | low_empty;
    assign full       = w_full;
    assign level      = r_level;
    assign outdata    = w_valid ? r_mem[r_rd_ptr] : '0;
    assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_pipe_reg_nwrite_port.sv
// ---------------------------------------------------------------------------
// tb_pipe_reg_nwrite_port
//
// Two instances share one stimulus stream:
//   dut_a : NPORTS=3, DEPTH=2, OVERWRITE=0, DROP_W=2 (drop policy, fast saturation)
//   dut_b : NPORTS=3, DEPTH=2, OVERWRITE=1, DROP_W=8 (overwrite policy)
// Expected head data is queued per instance when writes are driven and
// popped when the instance drains an entry.
// ---------------------------------------------------------------------------
module tb_pipe_reg_nwrite_port;

    logic        clock;
    logic        rst;
    logic [2:0]  wr_en;
    logic [23:0] indata;
    logic        low_empty;
    logic        clr_drop;

    logic [2:0]  a_grant, b_grant;
    logic        a_valid, b_valid, a_curr_empty, b_curr_empty;
    logic        a_sum_empty, b_sum_empty, a_full, b_full;
    logic [1:0]  a_level, b_level;
    logic [7:0]  a_outdata, b_outdata;
    logic [1:0]  a_drop;
    logic [7:0]  b_drop;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    pipe_reg_nwrite_port #(.DSIZE(8), .NPORTS(3), .DEPTH(2), .OVERWRITE(0), .DROP_W(2)) dut_a (
        .clock(clock), .rst(rst), .wr_en(wr_en), .indata(indata),
        .low_empty(low_empty), .clr_drop(clr_drop), .grant(a_grant),
        .valid(a_valid), .curr_empty(a_curr_empty), .sum_empty(a_sum_empty),
        .full(a_full), .level(a_level), .outdata(a_outdata), .drop_cnt(a_drop)
    );

    pipe_reg_nwrite_port #(.DSIZE(8), .NPORTS(3), .DEPTH(2), .OVERWRITE(1), .DROP_W(8)) dut_b (
        .clock(clock), .rst(rst), .wr_en(wr_en), .indata(indata),
        .low_empty(low_empty), .clr_drop(clr_drop), .grant(b_grant),
        .valid(b_valid), .curr_empty(b_curr_empty), .sum_empty(b_sum_empty),
        .full(b_full), .level(b_level), .outdata(b_outdata), .drop_cnt(b_drop)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic next_cycle;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; wr_en = '0; indata = '0; low_empty = 1'b0; clr_drop = 1'b0;
        repeat (2) next_cycle();
        n_cmp++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid_a: got %b want 0", a_valid); end
        n_cmp++; if (a_curr_empty !== 1'b1) begin n_err++; $display("FAIL rst_curr_empty_a: got %b want 1", a_curr_empty); end
        n_cmp++; if (a_full !== 1'b0) begin n_err++; $display("FAIL rst_full_a: got %b want 0", a_full); end
        n_cmp++; if (a_level !== 2'd0) begin n_err++; $display("FAIL rst_level_a: got %0d want 0", a_level); end
        n_cmp++; if (a_outdata !== 8'h00) begin n_err++; $display("FAIL rst_outdata_a: got %h want 00", a_outdata); end
        n_cmp++; if (a_drop !== 2'd0 || b_drop !== 8'd0) begin n_err++; $display("FAIL rst_drop: got %0d/%0d want 0/0", a_drop, b_drop); end
        n_cmp++; if (a_sum_empty !== 1'b1) begin n_err++; $display("FAIL rst_sum_empty_lo0: got %b want 1", a_sum_empty); end
        low_empty = 1'b1; #1;
        n_cmp++; if (b_sum_empty !== 1'b1) begin n_err++; $display("FAIL rst_sum_empty_lo1: got %b want 1", b_sum_empty); end
        low_empty = 1'b0;
        rst = 1'b0;
        $display("reset released at %0t", $time);
        next_cycle();
    endtask

    task automatic test_priority;
        logic [7:0] e;
        wr_en = 3'b110; indata = {8'h33, 8'h22, 8'h00}; low_empty = 1'b0; #1;
        n_cmp++; if (a_grant !== 3'b010) begin n_err++; $display("FAIL prio_grant: got %b want 010", a_grant); end
        qa.push_back(8'h22); qb.push_back(8'h22);
        $display("write ports=110 data p1=22 p2=33");
        next_cycle();
        wr_en = 3'b000; #1;
        n_cmp++; if (a_grant !== 3'b000) begin n_err++; $display("FAIL prio_grant_idle: got %b want 000", a_grant); end
        n_cmp++; if (a_level !== 2'd1) begin n_err++; $display("FAIL prio_level: got %0d want 1", a_level); end
        n_cmp++; if (a_drop !== 2'd1 || b_drop !== 8'd1) begin n_err++; $display("FAIL prio_drop: got %0d/%0d want 1/1", a_drop, b_drop); end
        low_empty = 1'b1;
        for (int c = 0; c < 4 && (qa.size() > 0 || qb.size() > 0); c++) begin
            if (qa.size() > 0) begin
                e = qa.pop_front();
                n_cmp++; if (a_valid !== 1'b1 || a_outdata !== e) begin n_err++; $display("FAIL prio_pop_a: got v=%b %h want v=1 %h", a_valid, a_outdata, e); end
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                n_cmp++; if (b_valid !== 1'b1 || b_outdata !== e) begin n_err++; $display("FAIL prio_pop_b: got v=%b %h want v=1 %h", b_valid, b_outdata, e); end
            end
            $display("pop a=%h b=%h", a_outdata, b_outdata);
            next_cycle();
        end
        n_cmp++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin n_err++; $display("FAIL prio_drained: got %b/%b want 0/0", a_valid, b_valid); end
        low_empty = 1'b0; clr_drop = 1'b1;
        next_cycle();
        clr_drop = 1'b0;
    endtask

    task automatic test_fill_stall;
        logic [7:0] e;
        low_empty = 1'b0;
        wr_en = 3'b001; indata = {16'h0, 8'hA1}; next_cycle();
        indata = {16'h0, 8'hA2}; next_cycle();
        indata = {16'h0, 8'hA3}; #1;
        n_cmp++; if (a_grant !== 3'b001) begin n_err++; $display("FAIL fill_grant_full: got %b want 001", a_grant); end
        next_cycle();
        wr_en = 3'b000;
        qa.push_back(8'hA1); qa.push_back(8'hA2);
        qb.push_back(8'hA1); qb.push_back(8'hA3);
        $display("write A1 A2 A3 on port0 with low_empty=0");
        n_cmp++; if (a_full !== 1'b1 || a_level !== 2'd2) begin n_err++; $display("FAIL fill_full_a: got full=%b lvl=%0d want 1/2", a_full, a_level); end
        n_cmp++; if (a_drop !== 2'd1) begin n_err++; $display("FAIL fill_drop_a: got %0d want 1", a_drop); end
        n_cmp++; if (b_full !== 1'b1 || b_level !== 2'd2) begin n_err++; $display("FAIL ovw_full_b: got full=%b lvl=%0d want 1/2", b_full, b_level); end
        n_cmp++; if (b_drop !== 8'd0) begin n_err++; $display("FAIL ovw_drop_b: got %0d want 0", b_drop); end
        next_cycle();
        n_cmp++; if (a_outdata !== 8'hA1) begin n_err++; $display("FAIL stall_hold_a: got %h want a1", a_outdata); end
        low_empty = 1'b1;
        for (int c = 0; c < 6 && (qa.size() > 0 || qb.size() > 0); c++) begin
            if (qa.size() > 0) begin
                e = qa.pop_front();
                n_cmp++; if (a_valid !== 1'b1 || a_outdata !== e) begin n_err++; $display("FAIL fill_pop_a: got v=%b %h want v=1 %h", a_valid, a_outdata, e); end
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                n_cmp++; if (b_valid !== 1'b1 || b_outdata !== e) begin n_err++; $display("FAIL ovw_pop_b: got v=%b %h want v=1 %h", b_valid, b_outdata, e); end
            end
            $display("pop a=%h b=%h", a_outdata, b_outdata);
            next_cycle();
        end
        n_cmp++; if (a_valid !== 1'b0 || a_outdata !== 8'h00 || a_curr_empty !== 1'b1) begin n_err++; $display("FAIL fill_empty_a: got v=%b %h ce=%b want 0 00 1", a_valid, a_outdata, a_curr_empty); end
        n_cmp++; if (b_valid !== 1'b0 || b_outdata !== 8'h00) begin n_err++; $display("FAIL ovw_empty_b: got v=%b %h want 0 00", b_valid, b_outdata); end
        low_empty = 1'b0; clr_drop = 1'b1;
        next_cycle();
        clr_drop = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [7:0] e;
        low_empty = 1'b0;
        wr_en = 3'b001; indata = {16'h0, 8'h10}; next_cycle();
        indata = {16'h0, 8'h11}; next_cycle();
        qa.push_back(8'h10); qa.push_back(8'h11); qb.push_back(8'h10); qb.push_back(8'h11);
        n_cmp++; if (a_full !== 1'b1) begin n_err++; $display("FAIL b2b_full: got %b want 1", a_full); end
        indata = {16'h0, 8'h12}; low_empty = 1'b1;
        qa.push_back(8'h12); qb.push_back(8'h12);
        $display("write 12 with low_empty=1 while full");
        e = qa.pop_front(); void'(qb.pop_front());
        n_cmp++; if (a_outdata !== e) begin n_err++; $display("FAIL b2b_head0: got %h want %h", a_outdata, e); end
        next_cycle();
        wr_en = 3'b000;
        n_cmp++; if (a_level !== 2'd2 || b_level !== 2'd2) begin n_err++; $display("FAIL b2b_level: got %0d/%0d want 2/2", a_level, b_level); end
        for (int c = 0; c < 6 && (qa.size() > 0 || qb.size() > 0); c++) begin
            if (qa.size() > 0) begin
                e = qa.pop_front();
                n_cmp++; if (a_valid !== 1'b1 || a_outdata !== e) begin n_err++; $display("FAIL b2b_pop_a: got v=%b %h want v=1 %h", a_valid, a_outdata, e); end
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                n_cmp++; if (b_valid !== 1'b1 || b_outdata !== e) begin n_err++; $display("FAIL b2b_pop_b: got v=%b %h want v=1 %h", b_valid, b_outdata, e); end
            end
            $display("pop a=%h b=%h", a_outdata, b_outdata);
            next_cycle();
        end
        n_cmp++; if (a_valid !== 1'b0 || a_drop !== 2'd0) begin n_err++; $display("FAIL b2b_end: got v=%b drop=%0d want 0/0", a_valid, a_drop); end
        low_empty = 1'b0;
    endtask

    task automatic test_saturation_reset;
        low_empty = 1'b0;
        wr_en = 3'b011; indata = {8'h00, 8'hD1, 8'hC1}; next_cycle();
        indata = {8'h00, 8'hD2, 8'hC2}; next_cycle();
        n_cmp++; if (a_drop !== 2'd2 || b_drop !== 8'd2) begin n_err++; $display("FAIL sat_drop2: got %0d/%0d want 2/2", a_drop, b_drop); end
        wr_en = 3'b111; indata = {8'hE3, 8'hD3, 8'hC3}; next_cycle();
        n_cmp++; if (a_drop !== 2'd3 || b_drop !== 8'd4) begin n_err++; $display("FAIL sat_drop_sat: got %0d/%0d want 3/4", a_drop, b_drop); end
        next_cycle();
        n_cmp++; if (a_drop !== 2'd3 || b_drop !== 8'd6) begin n_err++; $display("FAIL sat_hold: got %0d/%0d want 3/6", a_drop, b_drop); end
        n_cmp++; if (a_outdata !== 8'hC1) begin n_err++; $display("FAIL sat_head: got %h want c1", a_outdata); end
        wr_en = 3'b011; clr_drop = 1'b1; next_cycle();
        clr_drop = 1'b0;
        n_cmp++; if (a_drop !== 2'd0 || b_drop !== 8'd0) begin n_err++; $display("FAIL clr_prio: got %0d/%0d want 0/0", a_drop, b_drop); end
        low_empty = 1'b1; next_cycle();
        wr_en = 3'b000; next_cycle();
        low_empty = 1'b0;
        n_cmp++; if (a_level !== 2'd1 || a_drop !== 2'd1) begin n_err++; $display("FAIL pre_rst: got lvl=%0d drop=%0d want 1/1", a_level, a_drop); end
        #3;
        rst = 1'b1; wr_en = 3'b001; indata = {16'h0, 8'h77};
        #1;
        $display("async reset asserted mid-cycle at %0t", $time);
        n_cmp++; if (a_level !== 2'd0 || a_valid !== 1'b0 || a_outdata !== 8'h00 || a_full !== 1'b0) begin n_err++; $display("FAIL arst_a: got lvl=%0d v=%b %h f=%b want 0 0 00 0", a_level, a_valid, a_outdata, a_full); end
        n_cmp++; if (a_drop !== 2'd0 || b_level !== 2'd0 || a_sum_empty !== 1'b1) begin n_err++; $display("FAIL arst_misc: got drop=%0d lvlb=%0d se=%b want 0 0 1", a_drop, b_level, a_sum_empty); end
        next_cycle();
        n_cmp++; if (a_level !== 2'd0) begin n_err++; $display("FAIL arst_write_ignored: got %0d want 0", a_level); end
        rst = 1'b0; indata = {16'h0, 8'h5A};
        next_cycle();
        wr_en = 3'b000;
        $display("write 5A after reset release");
        n_cmp++; if (a_outdata !== 8'h5A || a_level !== 2'd1) begin n_err++; $display("FAIL post_rst_write: got %h lvl=%0d want 5a/1", a_outdata, a_level); end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_fill_stall();
        test_back_to_back();
        test_saturation_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
